// File: rtl/gamma_pkg.sv
// Shared constants, FSM encoding and the linear-curve helper for the gamma LUT stage.
// The optional pixel bypass is controlled by the GAMMA_BYPASS_EN macro in the users of this package.
package gamma_pkg;

  localparam int DIN_W  = 8;
  localparam int DOUT_W = 12;
  localparam int DEPTH  = 256;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } fsm_t;

  // Replicating the top nibble maps 0xFF to the full-scale 0xFFF.
  function automatic logic [DOUT_W-1:0] lin_expand(input logic [DIN_W-1:0] a);
    return {a, a[DIN_W-1:DIN_W-4]};
  endfunction

endpackage

// File: rtl/gamma_lut_ctrl_if.sv
// Pixel stream, table-config and status bundle of the gamma LUT stage.
// GAMMA_BYPASS_EN adds the per-pixel I_bypass input.
interface gamma_lut_ctrl_if;
  import gamma_pkg::*;

  // Streams carry no backpressure: a beat is transferred on every cycle its
  // valid is high, and the config strobes act on the cycle they are high.
  logic              I_pix_valid;
  logic [DIN_W-1:0]  I_pix_data;
  logic              I_hs;
  logic              I_vs;
`ifdef GAMMA_BYPASS_EN
  logic              I_bypass;
`endif
  logic              O_pix_valid;
  logic [DOUT_W-1:0] O_pix_data;
  logic              O_hs;
  logic              O_vs;
  logic              I_cfg_wr;
  logic [DIN_W-1:0]  I_cfg_addr;
  logic [DOUT_W-1:0] I_cfg_data;
  logic              I_cfg_commit;
  logic              O_cfg_err;
  logic              O_ready;
  logic              O_pending;
  logic              O_active_bank;
  fsm_t              dbg_state;

  modport master (
`ifdef GAMMA_BYPASS_EN
    output I_bypass,
`endif
    output I_pix_valid, I_pix_data, I_hs, I_vs,
    output I_cfg_wr, I_cfg_addr, I_cfg_data, I_cfg_commit,
    input  O_pix_valid, O_pix_data, O_hs, O_vs,
    input  O_cfg_err, O_ready, O_pending, O_active_bank, dbg_state
  );

  modport slave (
`ifdef GAMMA_BYPASS_EN
    input  I_bypass,
`endif
    input  I_pix_valid, I_pix_data, I_hs, I_vs,
    input  I_cfg_wr, I_cfg_addr, I_cfg_data, I_cfg_commit,
    output O_pix_valid, O_pix_data, O_hs, O_vs,
    output O_cfg_err, O_ready, O_pending, O_active_bank, dbg_state
  );

endinterface

// File: rtl/gamma_lut_ram.sv
// One gamma table bank: single write port muxed between default fill and host config,
// plus one registered read port for the pixel path.
module gamma_lut_ram
  import gamma_pkg::*;
(
  input  logic              clk_i,
  input  logic              fill_en_i,
  input  logic [DIN_W-1:0]  fill_addr_i,
  input  logic [DOUT_W-1:0] fill_data_i,
  input  logic              cfg_we_i,
  input  logic [DIN_W-1:0]  cfg_addr_i,
  input  logic [DOUT_W-1:0] cfg_data_i,
  input  logic [DIN_W-1:0]  raddr_i,
  output logic [DOUT_W-1:0] rdata_o
);

  logic [DOUT_W-1:0] mem_q [DEPTH];
  logic [DOUT_W-1:0] rdata_q;
  logic              we;
  logic [DIN_W-1:0]  waddr;
  logic [DOUT_W-1:0] wdata;

  // The fill owns the port while it runs; the controller never enables both.
  always_comb begin
    we    = 1'b0;
    waddr = cfg_addr_i;
    wdata = cfg_data_i;
    if (fill_en_i) begin
      we    = 1'b1;
      waddr = fill_addr_i;
      wdata = fill_data_i;
    end else if (cfg_we_i) begin
      we    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gamma_lut_ctrl.sv
// Double-buffered programmable gamma stage: 8-bit pixel in, 12-bit pixel out, bank swap only at frame start.
// Build with GAMMA_BYPASS_EN to add a per-pixel linear bypass.
module gamma_lut_ctrl
  import gamma_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_rst,
  gamma_lut_ctrl_if.slave bus
);

  localparam logic [DIN_W-1:0] LAST_ADDR = DIN_W'(DEPTH - 1);

  fsm_t              state_q, state_d;
  logic [DIN_W-1:0]  fill_q, fill_d;
  logic              active_q, active_d;
  logic              pending_q, pending_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              vs_prev_q;
  logic              vs_rise;
  logic              fill_en;
  logic              shadow_we;
  logic [DOUT_W-1:0] rdata0, rdata1;

  logic              valid_s1_q, hs_s1_q, vs_s1_q, sel_s1_q, init_s1_q;
`ifdef GAMMA_BYPASS_EN
  logic              byp_s1_q;
  logic [DIN_W-1:0]  din_s1_q;
`endif
  logic              valid_s2_q, hs_s2_q, vs_s2_q;
  logic [DOUT_W-1:0] pix_q, pix_d;

  assign vs_rise   = bus.I_vs & ~vs_prev_q;
  assign fill_en   = (state_q == INIT);
  assign shadow_we = (state_q == RUN) & bus.I_cfg_wr;

  // The shadow bank is whichever bank the pixel path is not reading.
  gamma_lut_ram u_bank0 (
    .clk_i       (I_clk),
    .fill_en_i   (fill_en),
    .fill_addr_i (fill_q),
    .fill_data_i (lin_expand(fill_q)),
    .cfg_we_i    (shadow_we & active_q),
    .cfg_addr_i  (bus.I_cfg_addr),
    .cfg_data_i  (bus.I_cfg_data),
    .raddr_i     (bus.I_pix_data),
    .rdata_o     (rdata0)
  );

  gamma_lut_ram u_bank1 (
    .clk_i       (I_clk),
    .fill_en_i   (fill_en),
    .fill_addr_i (fill_q),
    .fill_data_i (lin_expand(fill_q)),
    .cfg_we_i    (shadow_we & ~active_q),
    .cfg_addr_i  (bus.I_cfg_addr),
    .cfg_data_i  (bus.I_cfg_data),
    .raddr_i     (bus.I_pix_data),
    .rdata_o     (rdata1)
  );

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    active_d  = active_q;
    pending_d = pending_q;
    ready_d   = ready_q;
    err_d     = 1'b0;
    case (state_q)
      INIT: begin
        fill_d = fill_q + 1'b1;
        if (bus.I_cfg_wr || bus.I_cfg_commit) begin
          err_d = 1'b1;
        end
        if (fill_q == LAST_ADDR) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        // A commit that coincides with frame start swaps at once, skipping PEND.
        if (bus.I_cfg_commit) begin
          if (vs_rise) begin
            active_d = ~active_q;
          end else begin
            state_d   = PEND;
            pending_d = 1'b1;
          end
        end
      end
      PEND: begin
        if (bus.I_cfg_wr) begin
          err_d = 1'b1;
        end
        if (vs_rise) begin
          active_d  = ~active_q;
          pending_d = 1'b0;
          state_d   = RUN;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= INIT;
      fill_q    <= '0;
      active_q  <= 1'b0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      vs_prev_q <= bus.I_vs;
    end
  end

  // Stage 1: RAM read happens inside the banks; control bits travel alongside.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      valid_s1_q <= 1'b0;
      hs_s1_q    <= 1'b0;
      vs_s1_q    <= 1'b0;
      sel_s1_q   <= 1'b0;
      init_s1_q  <= 1'b0;
`ifdef GAMMA_BYPASS_EN
      byp_s1_q   <= 1'b0;
      din_s1_q   <= '0;
`endif
    end else begin
      valid_s1_q <= bus.I_pix_valid;
      hs_s1_q    <= bus.I_hs;
      vs_s1_q    <= bus.I_vs;
      sel_s1_q   <= active_q;
      init_s1_q  <= (state_q == INIT);
`ifdef GAMMA_BYPASS_EN
      byp_s1_q   <= bus.I_bypass;
      din_s1_q   <= bus.I_pix_data;
`endif
    end
  end

  always_comb begin
    pix_d = pix_q;
    if (valid_s1_q) begin
      if (init_s1_q) begin
        pix_d = '0;
`ifdef GAMMA_BYPASS_EN
      end else if (byp_s1_q) begin
        pix_d = lin_expand(din_s1_q);
`endif
      end else begin
        pix_d = sel_s1_q ? rdata1 : rdata0;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      valid_s2_q <= 1'b0;
      hs_s2_q    <= 1'b0;
      vs_s2_q    <= 1'b0;
      pix_q      <= '0;
    end else begin
      valid_s2_q <= valid_s1_q;
      hs_s2_q    <= hs_s1_q;
      vs_s2_q    <= vs_s1_q;
      pix_q      <= pix_d;
    end
  end

  assign bus.O_pix_valid   = valid_s2_q;
  assign bus.O_pix_data    = pix_q;
  assign bus.O_hs          = hs_s2_q;
  assign bus.O_vs          = vs_s2_q;
  assign bus.O_cfg_err     = err_q;
  assign bus.O_ready       = ready_q;
  assign bus.O_pending     = pending_q;
  assign bus.O_active_bank = active_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Self-checking bench for gamma_lut_ctrl against a table/queue reference model.
// Define GAMMA_BYPASS_EN for both bench and RTL to exercise the bypass scenario.
module tb_gamma_lut_ctrl;
  import gamma_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  gamma_lut_ctrl_if bus ();

  gamma_lut_ctrl dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [11:0] tbl [2][256];
  logic        m_active, m_pending, m_ready, m_err, m_vs_prev;
  int          m_init_cnt;
  logic [11:0] m_last;
  logic [14:0] exp_q [$];

  function automatic logic [11:0] lin_ref(input int a);
    return 12'(a * 16 + a / 16);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++)
        tbl[b][i] = lin_ref(i);
    m_active   = 1'b0;
    m_pending  = 1'b0;
    m_ready    = 1'b0;
    m_err      = 1'b0;
    m_vs_prev  = 1'b0;
    m_init_cnt = 0;
    m_last     = 12'h0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [7:0] d, input logic hs, input logic vs,
                      input logic wr, input logic [7:0] wa, input logic [11:0] wd,
                      input logic cm, input logic byp);
    logic        vs_rise;
    logic        byp_eff;
    logic [14:0] got;
    logic [14:0] exp;
    fsm_t        exp_st;
    bus.I_pix_valid  = v;
    bus.I_pix_data   = d;
    bus.I_hs         = hs;
    bus.I_vs         = vs;
    bus.I_cfg_wr     = wr;
    bus.I_cfg_addr   = wa;
    bus.I_cfg_data   = wd;
    bus.I_cfg_commit = cm;
`ifdef GAMMA_BYPASS_EN
    bus.I_bypass     = byp;
    byp_eff          = byp;
`else
    byp_eff          = 1'b0;
`endif
    vs_rise = vs && !m_vs_prev;
    if (v) m_last = !m_ready ? 12'h0 : (byp_eff ? lin_ref(int'(d)) : tbl[m_active][d]);
    exp_q.push_back({v, hs, vs, m_last});
    m_err = 1'b0;
    if (!m_ready) begin
      if (wr || cm) m_err = 1'b1;
      m_init_cnt++;
      if (m_init_cnt == 256) m_ready = 1'b1;
    end else if (!m_pending) begin
      if (wr) tbl[!m_active][wa] = wd;
      if (cm) begin
        if (vs_rise) m_active = !m_active;
        else         m_pending = 1'b1;
      end
    end else begin
      if (wr) m_err = 1'b1;
      if (vs_rise) begin
        m_active  = !m_active;
        m_pending = 1'b0;
      end
    end
    m_vs_prev = vs;
    @(posedge clk);
    #1;
    exp_st = !m_ready ? INIT : (m_pending ? PEND : RUN);
    n_cmp++;
    if ({bus.O_ready, bus.O_pending, bus.O_active_bank, bus.O_cfg_err, bus.dbg_state} !==
        {m_ready, m_pending, m_active, m_err, exp_st}) begin
      n_err++;
      $display("FAIL ctrl t=%0t got rdy/pend/bank/err/st=%b%b%b%b/%0d expected %b%b%b%b/%0d",
               $time, bus.O_ready, bus.O_pending, bus.O_active_bank, bus.O_cfg_err, bus.dbg_state,
               m_ready, m_pending, m_active, m_err, exp_st);
    end
    if (exp_q.size() >= 2) begin
      exp = exp_q.pop_front();
      got = {bus.O_pix_valid, bus.O_hs, bus.O_vs, bus.O_pix_data};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL pix t=%0t got v/hs/vs/data=%b%b%b/%h expected %b%b%b/%h",
                 $time, got[14], got[13], got[12], got[11:0], exp[14], exp[13], exp[12], exp[11:0]);
      end
    end
  endtask

  task automatic pix(input logic v, input logic [7:0] d, input logic vs);
    step(v, d, 1'($urandom_range(0, 1)), vs, 1'b0, 8'h0, 12'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step_inputs_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    n_cmp++;
    if ({bus.O_pix_valid, bus.O_pix_data, bus.O_hs, bus.O_vs, bus.O_cfg_err, bus.O_ready,
         bus.O_pending, bus.O_active_bank, bus.dbg_state} !== {20'h0, INIT}) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b d=%h hs=%b vs=%b err=%b rdy=%b pend=%b bank=%b st=%0d expected all 0, INIT",
               bus.O_pix_valid, bus.O_pix_data, bus.O_hs, bus.O_vs, bus.O_cfg_err, bus.O_ready,
               bus.O_pending, bus.O_active_bank, bus.dbg_state);
    end
  endtask

  task automatic step_inputs_idle();
    bus.I_pix_valid  = 1'b0;
    bus.I_pix_data   = 8'h0;
    bus.I_hs         = 1'b0;
    bus.I_vs         = 1'b0;
    bus.I_cfg_wr     = 1'b0;
    bus.I_cfg_addr   = 8'h0;
    bus.I_cfg_data   = 12'h0;
    bus.I_cfg_commit = 1'b0;
`ifdef GAMMA_BYPASS_EN
    bus.I_bypass     = 1'b0;
`endif
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  // Run the default fill with random pixels and rejected config pokes.
  task automatic run_init();
    for (int i = 0; i < 256; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0,
           ($urandom_range(0, 15) == 0), 8'($urandom), 12'($urandom),
           ($urandom_range(0, 31) == 0), 1'b0);
      if (i == 254) check_bit("ready_low_at_255", bus.O_ready, 1'b0);
    end
    check_bit("ready_high_at_256", bus.O_ready, 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    run_init();
    pix(1'b1, 8'h80, 1'b0);
    pix(1'b1, 8'hFF, 1'b0);
    n_cmp++;
    if (bus.O_pix_data !== 12'h808) begin
      n_err++;
      $display("FAIL lin_0x80 got %h expected 808", bus.O_pix_data);
    end
    pix(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (bus.O_pix_data !== 12'hFFF) begin
      n_err++;
      $display("FAIL lin_0xFF got %h expected fff", bus.O_pix_data);
    end
  endtask

  task automatic test_commit_swap();
    step(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 8'h10, 12'h123, 1'b0, 1'b0);
    pix(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h0, 12'h0, 1'b1, 1'b0);
    check_bit("pending_after_commit", bus.O_pending, 1'b1);
    for (int i = 0; i < 5; i++) pix(1'b1, 8'h10, 1'b0);
    pix(1'b1, 8'h10, 1'b1);
    check_bit("bank_after_swap", bus.O_active_bank, 1'b1);
    check_bit("pending_after_swap", bus.O_pending, 1'b0);
    pix(1'b1, 8'h10, 1'b1);
    pix(1'b1, 8'h20, 1'b1);
    n_cmp++;
    if (bus.O_pix_data !== 12'h123) begin
      n_err++;
      $display("FAIL new_frame_pix got %h expected 123", bus.O_pix_data);
    end
    for (int i = 0; i < 4; i++) pix(1'b1, 8'($urandom), 1'b0);
  endtask

  task automatic test_pend_reject();
    logic [11:0] wd1;
    logic [11:0] wd2;
    wd1 = 12'($urandom);
    wd2 = ~wd1;
    step(1'b0, 8'h0, 1'b0, 1'b0, 1'b1, 8'h05, wd1, 1'b0, 1'b0);
    step(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h0, 1'b1, 1'b0);
    step(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h05, wd2, 1'b0, 1'b0);
    check_bit("pend_wr_err", bus.O_cfg_err, 1'b1);
    step(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 12'h0, 1'b1, 1'b0);
    check_bit("pend_recommit_no_err", bus.O_cfg_err, 1'b0);
    pix(1'b1, 8'h05, 1'b1);
    pix(1'b1, 8'h05, 1'b1);
    pix(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (bus.O_pix_data !== wd1) begin
      n_err++;
      $display("FAIL pend_write_dropped got %h expected %h", bus.O_pix_data, wd1);
    end
    pix(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_commit_on_vs();
    logic bank_before;
    pix(1'b1, 8'($urandom), 1'b0);
    bank_before = m_active;
    step(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0, 8'h0, 12'h0, 1'b1, 1'b0);
    check_bit("vs_commit_no_pending", bus.O_pending, 1'b0);
    check_bit("vs_commit_swapped", bus.O_active_bank, !bank_before);
    for (int i = 0; i < 3; i++) pix(1'b1, 8'($urandom), 1'b1);
    pix(1'b0, 8'h0, 1'b0);
  endtask

  task automatic test_random();
    int   frame_cnt;
    logic vs;
    frame_cnt = 0;
    vs = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      frame_cnt++;
      if (frame_cnt >= int'($urandom_range(20, 60))) begin
        vs = 1'b1;
        frame_cnt = 0;
      end else if (frame_cnt > 2) begin
        vs = 1'b0;
      end
      step(1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom),
           1'($urandom_range(0, 1)), vs,
           ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)), 12'($urandom),
           ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_pend();
    pix(1'b1, 8'h01, 1'b0);
    step(1'b0, 8'h0, 1'b0, 1'b0, 1'b1, 8'h33, 12'hABC, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h0, 12'h0, 1'b1, 1'b0);
    check_bit("pend_before_reset", bus.O_pending, 1'b1);
    for (int i = 0; i < 3; i++) pix(1'b1, 8'($urandom), 1'b0);
    do_reset();
    run_init();
    for (int i = 0; i < 64; i++) pix(1'b1, 8'($urandom), 1'b0);
    pix(1'b1, 8'h33, 1'b1);
    pix(1'b0, 8'h00, 1'b1);
    pix(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (bus.O_pix_data !== 12'h333) begin
      n_err++;
      $display("FAIL reset_lost_commit got %h expected 333", bus.O_pix_data);
    end
  endtask

`ifdef GAMMA_BYPASS_EN
  task automatic test_bypass();
    step(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h0, 12'h0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0, 12'h0, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.O_pix_valid, bus.O_hs, bus.O_vs, bus.O_pix_data} !== {3'b111, 12'h3C3}) begin
      n_err++;
      $display("FAIL bypass got v/hs/vs/data=%b%b%b/%h expected 111/3c3",
               bus.O_pix_valid, bus.O_hs, bus.O_vs, bus.O_pix_data);
    end
    pix(1'b0, 8'h00, 1'b0);
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    step_inputs_idle();
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_commit_swap();
    test_pend_reject();
    test_commit_on_vs();
    test_random();
`ifdef GAMMA_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
